// File: rtl/selftest_sequencer.sv
// LFSR-driven self-test sequencer: streams patterns to a DUT, compacts the responses
// into a MISR and reports the run status as a 5-bit pad code.
module selftest_sequencer #(
  parameter int           W       = 16,
  parameter logic [W-1:0] TAPS    = 16'hB400,
  parameter logic [W-1:0] SEED    = 16'h0001,
  parameter int           NUM_VEC = 256,
  parameter logic [W-1:0] EXP_SIG = 16'h0000,
  parameter int           TIMEOUT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         i_enable,
  input  logic         i_test,
  output logic [W-1:0] o_stim,
  output logic         o_stim_valid,
  input  logic         i_stim_ready,
  input  logic [W-1:0] i_resp,
  input  logic         i_resp_valid,
  output logic [4:0]   o_result
);

  localparam int CW = $clog2(NUM_VEC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_RUN, S_DRAIN, S_CMP, S_PASS, S_FAIL_SIG, S_FAIL_TO
  } state_t;

  state_t         state;
  logic           en_s1, en_s, en_prev, test_s1, test_s;
  logic [1:0]     settle;
  logic           armed;
  logic           mode;
  logic           stim_valid;
  logic [W-1:0]   lfsr, misr;
  logic [CW-1:0]  stim_cnt, resp_cnt, resp_cnt_nx;
  logic [TW-1:0]  to_cnt;
  logic           rise, fall, xfer, accept, progress, timeout_hit, active;

  function automatic logic [W-1:0] galois(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? TAPS : '0);
  endfunction

  // Starts are only honoured once the synchronized enable has been seen low after
  // reset, so an enable still high across a reset cannot restart a run.
  assign rise        = en_s & ~en_prev & armed;
  assign fall        = ~en_s & en_prev;
  assign active      = (state == S_RUN) || (state == S_DRAIN);
  assign xfer        = stim_valid & i_stim_ready;
  assign accept      = i_resp_valid & active & (resp_cnt < CW'(NUM_VEC));
  assign progress    = xfer | accept;
  assign resp_cnt_nx = resp_cnt + CW'(accept);
  assign timeout_hit = !progress && (to_cnt == TW'(TIMEOUT - 1));

  assign o_stim       = lfsr;
  assign o_stim_valid = stim_valid;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      en_s1      <= 1'b0;
      en_s       <= 1'b0;
      en_prev    <= 1'b0;
      test_s1    <= 1'b0;
      test_s     <= 1'b0;
      settle     <= 2'b00;
      armed      <= 1'b0;
      mode       <= 1'b0;
      stim_valid <= 1'b0;
      lfsr       <= SEED;
      misr       <= '0;
      stim_cnt   <= '0;
      resp_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      en_s1   <= i_enable;
      en_s    <= en_s1;
      en_prev <= en_s;
      test_s1 <= i_test;
      test_s  <= test_s1;
      settle  <= {settle[0], 1'b1};
      if (settle[1] && !en_s) armed <= 1'b1;

      case (state)
        S_IDLE: if (rise) state <= S_SEED;
        S_SEED: begin
          if (fall) begin
            state <= S_IDLE;
          end else begin
            lfsr       <= SEED;
            misr       <= '0;
            stim_cnt   <= '0;
            resp_cnt   <= '0;
            to_cnt     <= '0;
            mode       <= test_s;
            stim_valid <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (fall) begin
            state      <= S_IDLE;
            stim_valid <= 1'b0;
          end else begin
            if (xfer) begin
              lfsr     <= galois(lfsr);
              stim_cnt <= stim_cnt + CW'(1);
            end
            if (accept) begin
              misr     <= galois(misr) ^ i_resp;
              resp_cnt <= resp_cnt_nx;
            end
            to_cnt <= progress ? '0 : to_cnt + TW'(1);
            if (timeout_hit) begin
              state      <= S_FAIL_TO;
              stim_valid <= 1'b0;
            end else if (state == S_RUN && xfer && stim_cnt == CW'(NUM_VEC - 1)) begin
              stim_valid <= 1'b0;
              state      <= (resp_cnt_nx == CW'(NUM_VEC)) ? S_CMP : S_DRAIN;
            end else if (state == S_DRAIN && resp_cnt == CW'(NUM_VEC)) begin
              state <= S_CMP;
            end
          end
        end
        S_CMP: begin
          if (fall)                          state <= S_IDLE;
          else if (!mode || misr == EXP_SIG) state <= S_PASS;
          else                               state <= S_FAIL_SIG;
        end
        S_PASS, S_FAIL_SIG, S_FAIL_TO: if (fall) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_result = 5'b00000;
    case (state)
      S_IDLE:     o_result = 5'b00000;
      S_SEED:     o_result = 5'b00001;
      S_RUN:      o_result = 5'b00010;
      S_DRAIN:    o_result = 5'b00100;
      S_CMP:      o_result = 5'b01000;
      S_PASS:     o_result = 5'b11111;
      S_FAIL_SIG: o_result = 5'b11110;
      S_FAIL_TO:  o_result = 5'b11100;
      default:    o_result = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_selftest_sequencer.sv
// Bench for selftest_sequencer: a single-vector instance for exact state timing and a
// 256-vector instance with a stimulus scoreboard and a polynomial-arithmetic signature model.
module tb_selftest_sequencer;

  localparam logic [15:0] TAPS_B   = 16'hB400;
  localparam logic [4:0]  R_IDLE   = 5'b00000;
  localparam logic [4:0]  R_SEED   = 5'b00001;
  localparam logic [4:0]  R_RUN    = 5'b00010;
  localparam logic [4:0]  R_CMP    = 5'b01000;
  localparam logic [4:0]  R_PASS   = 5'b11111;
  localparam logic [4:0]  R_FSIG   = 5'b11110;
  localparam logic [4:0]  R_FTO    = 5'b11100;

  // Multiply by x modulo the feedback polynomial.
  function automatic logic [15:0] mulx(input logic [15:0] v);
    logic [16:0] d;
    d = 17'(v) * 17'd2;
    return d[16] ? (d[15:0] ^ TAPS_B) : d[15:0];
  endfunction

  function automatic logic [15:0] loop_sig();
    logic [15:0] s, m;
    s = 16'h0001;
    m = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      m = mulx(m) ^ s;
      s = mulx(s);
    end
    return m;
  endfunction

  localparam logic [15:0] B_SIG = loop_sig();

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: one vector, expected signature 0x0001.
  logic        a_en = 1'b0, a_test = 1'b1, a_ready = 1'b1;
  logic [15:0] a_mask = 16'h0000;
  logic [15:0] a_stim, a_resp;
  logic        a_stim_valid, a_resp_valid;
  logic [4:0]  a_result;
  assign a_resp       = a_stim ^ a_mask;
  assign a_resp_valid = a_stim_valid & a_ready;

  selftest_sequencer #(.W(16), .TAPS(16'hB400), .SEED(16'h0001), .NUM_VEC(1),
                       .EXP_SIG(16'h0001), .TIMEOUT(1024)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_enable(a_en), .i_test(a_test),
    .o_stim(a_stim), .o_stim_valid(a_stim_valid), .i_stim_ready(a_ready),
    .i_resp(a_resp), .i_resp_valid(a_resp_valid), .o_result(a_result));

  // Instance B: 256 vectors, loopback signature, short timeout.
  logic        b_en = 1'b0, b_test = 1'b1, b_ready = 1'b1, b_force = 1'b0, b_resp_on = 1'b1;
  logic [15:0] b_mask = 16'h0000;
  logic [15:0] b_stim, b_resp;
  logic        b_stim_valid, b_resp_valid;
  logic [4:0]  b_result;
  assign b_resp       = b_force ? 16'hFFFF : (b_stim ^ b_mask);
  assign b_resp_valid = b_stim_valid & b_ready & b_resp_on;

  selftest_sequencer #(.W(16), .TAPS(16'hB400), .SEED(16'h0001), .NUM_VEC(256),
                       .EXP_SIG(B_SIG), .TIMEOUT(16)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_enable(b_en), .i_test(b_test),
    .o_stim(b_stim), .o_stim_valid(b_stim_valid), .i_stim_ready(b_ready),
    .i_resp(b_resp), .i_resp_valid(b_resp_valid), .o_result(b_result));

  logic [15:0] exp_q[$];
  int xfer_total = 0, resp_total = 0, last_prog = 0;
  int resp_base = 0;
  int rdy_mode = 0;
  logic limit3 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Ready / response-gate driver, updated just after each active edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: b_ready = 1'b1;
      1: b_ready = ~b_ready;
      default: b_ready = ($urandom_range(3) != 0);
    endcase
    b_resp_on = !(limit3 && (resp_total - resp_base) >= 3);
  end

  // Monitor: every stimulus transfer pops the next expected pattern word.
  always @(negedge clk) begin
    if (b_stim_valid && b_ready) begin
      xfer_total++;
      last_prog = cyc + 1;
      if (exp_q.size() == 0) chk("b_stim_unexpected", 32'(b_stim), 32'hDEAD_BEEF);
      else chk("b_stim_word", 32'(b_stim), 32'(exp_q.pop_front()));
    end
    if (b_resp_valid) begin
      resp_total++;
      last_prog = cyc + 1;
    end
  end

  task automatic wait_b(input logic [4:0] code, input int budget, input string name);
    int n = 0;
    while (b_result !== code && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(b_result), 32'(code));
  endtask

  // Load the scoreboard with the pattern stream and return the expected final code.
  task automatic prep_b(input logic t, input logic [15:0] mask, input logic frc,
                        output logic [4:0] code);
    logic [15:0] s, m;
    exp_q.delete();
    s = 16'h0001;
    m = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(s);
      m = mulx(m) ^ (frc ? 16'hFFFF : (s ^ mask));
      s = mulx(s);
    end
    code = (!t || m == B_SIG) ? R_PASS : R_FSIG;
  endtask

  task automatic run_b(input logic t, input logic [15:0] mask, input logic frc,
                       input int rmode, input string name);
    logic [4:0] code;
    int base;
    prep_b(t, mask, frc, code);
    rdy_mode = rmode;
    b_test = t;
    b_mask = mask;
    b_force = frc;
    base = xfer_total;
    step(3);
    b_en = 1'b1;
    wait_b(code, 1500, name);
    chk({name, "_xfers"}, 32'(xfer_total - base), 32'd256);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    b_en = 1'b0;
    step(4);
    chk({name, "_idle"}, 32'(b_result), 32'(R_IDLE));
  endtask

  initial begin
    int base;
    int n;
    logic [4:0] code;
    step(3);
    rst = 1'b0;
    step(5);
    chk("a_reset_result", 32'(a_result), 32'(R_IDLE));
    chk("b_reset_result", 32'(b_result), 32'(R_IDLE));
    chk("b_reset_valid", 32'(b_stim_valid), 32'd0);

    // Single-vector loopback with exact per-cycle state sequence.
    a_en = 1'b1;
    step();  chk("a_edge_k", 32'(a_result), 32'(R_IDLE));
    step();  chk("a_edge_k1", 32'(a_result), 32'(R_IDLE));
    step();  chk("a_seed", 32'(a_result), 32'(R_SEED));
    step();  chk("a_run", 32'(a_result), 32'(R_RUN));
    chk("a_stim_valid", 32'(a_stim_valid), 32'd1);
    chk("a_stim_seed", 32'(a_stim), 32'h0001);
    step();  chk("a_cmp", 32'(a_result), 32'(R_CMP));
    step();  chk("a_pass", 32'(a_result), 32'(R_PASS));
    step(5); chk("a_pass_sticky", 32'(a_result), 32'(R_PASS));
    a_en = 1'b0;
    step(2); chk("a_fall_pending", 32'(a_result), 32'(R_PASS));
    step();  chk("a_fall_idle", 32'(a_result), 32'(R_IDLE));

    // Corrupted response gives signature 0x0002, not the expected 0x0001.
    a_mask = 16'h0003;
    step(4);
    a_en = 1'b1;
    step(6); chk("a_fail_sig", 32'(a_result), 32'(R_FSIG));
    step(8); chk("a_fail_sig_sticky", 32'(a_result), 32'(R_FSIG));
    a_en = 1'b0;
    step(3); chk("a_fail_sig_idle", 32'(a_result), 32'(R_IDLE));

    // Continuity mode ignores the signature.
    a_test = 1'b0;
    a_mask = 16'(($urandom_range(65534)) + 1);
    step(4);
    a_en = 1'b1;
    step(6); chk("a_continuity", 32'(a_result), 32'(R_PASS));
    a_en = 1'b0;
    step(3); chk("a_continuity_idle", 32'(a_result), 32'(R_IDLE));

    // 256 vectors with alternating ready, then randomized ready/response/mode runs.
    run_b(1'b1, 16'h0000, 1'b0, 1, "b_toggle_pass");
    for (int r = 0; r < 4; r++) begin
      logic [15:0] m;
      m = ($urandom_range(1) != 0) ? 16'h0000 : 16'($urandom);
      run_b(1'($urandom_range(1)), m, 1'b0, 2, "b_random");
    end
    run_b(1'b0, 16'h0000, 1'b1, 2, "b_continuity_ffff");

    // Responses stop after three; drain must time out 16 cycles after last progress.
    prep_b(1'b1, 16'h0000, 1'b0, code);
    rdy_mode = 0;
    b_test = 1'b1;
    b_mask = 16'h0000;
    b_force = 1'b0;
    resp_base = resp_total;
    base = xfer_total;
    limit3 = 1'b1;
    step(3);
    b_en = 1'b1;
    wait_b(R_FTO, 600, "b_timeout");
    chk("b_timeout_latency", 32'(cyc - last_prog), 32'd16);
    chk("b_timeout_valid", 32'(b_stim_valid), 32'd0);
    chk("b_timeout_resps", 32'(resp_total - resp_base), 32'd3);
    chk("b_timeout_xfers", 32'(xfer_total - base), 32'd256);
    b_en = 1'b0;
    limit3 = 1'b0;
    step(4);
    chk("b_timeout_idle", 32'(b_result), 32'(R_IDLE));

    // Abort by enable fall after ten vectors.
    prep_b(1'b1, 16'h0000, 1'b0, code);
    base = xfer_total;
    step(2);
    b_en = 1'b1;
    n = 0;
    while ((xfer_total - base) < 10 && n < 100) begin
      step();
      n++;
    end
    chk("b_abort_reached10", 32'((xfer_total - base) >= 10), 32'd1);
    b_en = 1'b0;
    step(2); chk("b_abort_pending", 32'(b_result), 32'(R_RUN));
    step();  chk("b_abort_idle", 32'(b_result), 32'(R_IDLE));
    chk("b_abort_valid", 32'(b_stim_valid), 32'd0);

    // Reset mid-run; a held enable must not restart.
    prep_b(1'b1, 16'h0000, 1'b0, code);
    step(4);
    b_en = 1'b1;
    wait_b(R_RUN, 20, "b_second_run");
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("b_rst_idle", 32'(b_result), 32'(R_IDLE));
    chk("b_rst_valid", 32'(b_stim_valid), 32'd0);
    base = xfer_total;
    step(20);
    chk("b_rst_no_restart", 32'(b_result), 32'(R_IDLE));
    chk("b_rst_no_xfers", 32'(xfer_total - base), 32'd0);
    b_en = 1'b0;
    step(5);
    run_b(1'b1, 16'h0000, 1'b0, 0, "b_after_toggle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/selftest_sequencer.md
Name: selftest_sequencer

Overview:
- User-area self-test engine for the design wrapper. A rising edge on the pad-level enable starts a run.
- During a run the block issues an LFSR pattern stream to the design under test and compacts the responses into a MISR. It then compares the MISR against an expected signature.
- Run status is reported on a 5-bit code driven to the GPIO result pins. 5'b11111 means pass.

Parameters:
- W, 16, stimulus/response/LFSR/MISR width (4..32).
- TAPS, 16'hB400, Galois feedback polynomial shared by LFSR and MISR.
- SEED, 16'h0001, LFSR start value; must be nonzero.
- NUM_VEC, 256, vectors per run (1..65535).
- EXP_SIG, 16'h0000, expected final MISR value.
- TIMEOUT, 1024, maximum cycles without progress before failure.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- i_enable  in  1  asynchronous pad input; a rising edge starts a run.
- i_test  in  1  asynchronous pad input, sampled at run start. 1 = compare signature; 0 = continuity mode, no compare.
- o_stim  out  W  stimulus word (current LFSR state).
- o_stim_valid  out  1  stimulus valid.
- i_stim_ready  in  1  DUT accepts stimulus.
- i_resp  in  W  DUT response word.
- i_resp_valid  in  1  response valid; no backpressure.
- o_result  out  5  status code to pads.

Behaviour:
- Synchronizers: i_enable and i_test each pass through a 2-flop synchronizer. en_prev registers the synchronized enable.
  - rise = en_s & ~en_prev; fall = ~en_s & en_prev.
- Reset: state=IDLE, lfsr=SEED, misr=0, all counters 0, o_stim_valid=0, sync flops 0.
- o_result is a combinational decode of the state register (no extra latency).
  - IDLE 00000, SEED 00001, RUN 00010, DRAIN 00100, CMP 01000.
  - PASS 11111, FAIL_SIG 11110, FAIL_TO 11100.
- IDLE: on rise, go to SEED. Pin high before edge k gives o_result=00001 after edge k+2.
- SEED (1 cycle): lfsr<=SEED, misr<=0, stim_cnt<=0, resp_cnt<=0, to_cnt<=0, mode<=synchronized i_test. Then go to RUN.
- RUN: o_stim_valid=1, o_stim=lfsr.
  - On valid&ready: lfsr<=Galois step ({lfsr[W-2:0],0} ^ (lfsr[W-1]?TAPS:0)), stim_cnt++.
  - When the transfer with stim_cnt==NUM_VEC-1 completes: o_stim_valid=0 from the next cycle, go to DRAIN.
- Responses are accepted in RUN and DRAIN while resp_cnt<NUM_VEC.
  - Update: misr<={misr[W-2:0],0} ^ (misr[W-1]?TAPS:0) ^ i_resp; resp_cnt++.
  - Responses beyond NUM_VEC, and responses in any other state, are ignored.
  - A response may arrive in the same cycle as its stimulus transfer.
- DRAIN: when resp_cnt==NUM_VEC, go to CMP. If resp_cnt already equals NUM_VEC on RUN exit, go from RUN straight to CMP.
- Timeout: to_cnt clears on any stimulus transfer or accepted response and otherwise increments in RUN and DRAIN. When to_cnt reaches TIMEOUT-1 without progress, go to FAIL_TO. Timeout has priority over the RUN→DRAIN/CMP transition in the same cycle.
- CMP (1 cycle):
  - mode=0: go to PASS.
  - mode=1: misr==EXP_SIG goes to PASS, else FAIL_SIG.
- PASS, FAIL_SIG, FAIL_TO are sticky. On fall, return to IDLE. A new run needs a fresh rise. A rise can only occur after a fall, so it never restarts a run in flight.
- fall during SEED, RUN, DRAIN or CMP aborts the run: go to IDLE and drop o_stim_valid immediately.
- wb_rst_i asserted mid-run: next cycle is IDLE with all registers at reset values. A still-high enable does not restart the run; it must toggle.
- Counter widths are sized for NUM_VEC and TIMEOUT with no wrap. The LFSR may cycle freely.

Test Plan:
- Loopback (i_resp=o_stim, i_resp_valid=transfer, ready=1), NUM_VEC=1, SEED=1, EXP_SIG=1, i_test=1 → o_result 00001, 00010, then CMP, then 11111; misr=0x0001.
- Same setup with EXP_SIG=0x0002 → 11110 sticky; drop i_enable → 00000 three cycles later.
- NUM_VEC=256, ready toggling 1/0 each cycle, loopback, EXP_SIG from bench model → exactly 256 transfers, o_stim sequence matches model, then 11111.
- TIMEOUT=16, i_resp_valid held 0 after the first 3 responses → 11100 exactly 16 cycles after the last transfer or response; o_stim_valid=0.
- i_test=0, responses all 0xFFFF, EXP_SIG=0 → 11111 (continuity mode ignores the signature).
- Mid-RUN abort by i_enable fall at vector 10 → IDLE, valid drops. Then pulse wb_rst_i during a second run → IDLE; with enable held high there is no restart until enable toggles.
